ps2_scancode_rx: RTL and testbench
==================================

Name: ps2_scancode_rx

Overview:
- Receives PS/2 keyboard frames from the PS2_CLK/PS2_DAT pins and decodes them into one event per key press or release.
- Each event is a scancode byte plus break and extended flags.
- Sits directly upstream of the escape-room top level's puzzle/keypad logic, which consumes the one-cycle scancode_valid pulses.
- Receive-only; never drives the PS/2 lines. The top level ties the inout pins to high-Z.

Parameters:
- FILTER_LEN, 8: consecutive identical synchronized samples required before a filtered line changes value.
- TIMEOUT_CYCLES, 100000: CLOCK_50 cycles (2 ms) allowed between filtered falling edges mid-frame before the frame is aborted.

Ports:
- CLOCK_50  input  1  system clock, 50 MHz.
- reset  input  1  asynchronous, active-high reset.
- ps2_clk_in  input  1  raw PS2_CLK pin, asynchronous.
- ps2_dat_in  input  1  raw PS2_DAT pin, asynchronous.
- scancode  output  8  last decoded scancode; held until the next valid.
- scancode_valid  output  1  one-cycle pulse; scancode and flags are valid this cycle.
- is_break  output  1  the event was preceded by 0xF0 (key release).
- is_extended  output  1  the event was preceded by 0xE0.
- frame_error  output  1  one-cycle pulse on parity, stop or timeout error.
- busy  output  1  high while the FSM is not in IDLE.

Behaviour:
- Reset:
  - All outputs are 0 and the FSM is in IDLE.
  - Prefix flags, bit counter, shift register and timeout counter are cleared.
  - Filtered lines reset to 1 (bus idle).
  - Assertion mid-frame discards the partial frame immediately; no error pulse is generated.
- Input path:
  - Each pin passes through a 2-FF synchronizer, then a glitch filter.
  - The filtered value changes only after FILTER_LEN consecutive equal samples.
  - Pin-to-filtered latency is 2+FILTER_LEN cycles.
  - A PS/2 clock pulse shorter than FILTER_LEN cycles is ignored.
- Edge detect: fall_edge = filtered clock registered 1 and current 0. All data sampling happens on fall_edge, using the filtered data line.
- FSM states (ps2_pkg::rx_state_t):
  - IDLE: on fall_edge with data=0 (start bit), go to DATA with bit_cnt=0. On fall_edge with data=1, stay in IDLE and ignore it.
  - DATA: on each fall_edge, shift data in LSB-first. When bit_cnt=7, go to PARITY; otherwise increment bit_cnt.
  - PARITY: on fall_edge, capture the parity bit and go to STOP.
  - STOP: on fall_edge, check odd parity (XOR of 8 data bits and the parity bit equals 1) and stop bit = 1. Go to IDLE in all cases.
- Completion, in the cycle after the STOP fall_edge:
  - Good byte 0xE0: set ext_flag; no valid pulse.
  - Good byte 0xF0: set brk_flag; no valid pulse.
  - Any other good byte: scancode_valid=1; scancode=byte; is_break=brk_flag; is_extended=ext_flag. Both flags are cleared in the same cycle.
  - Bad parity or stop bit = 0: frame_error=1 for one cycle; both prefix flags cleared; scancode unchanged.
- Timeout:
  - The counter resets on every fall_edge and counts while not in IDLE.
  - When it reaches TIMEOUT_CYCLES: frame_error pulses once, FSM goes to IDLE, prefix flags are cleared.
  - The counter does not run in IDLE, so prefix flags persist between frames indefinitely.
- Simultaneity: a valid pulse and an error pulse never coincide. If a new start-bit edge arrives in the same cycle as the completion pulse, it is accepted.
- is_break and is_extended are registered with scancode and held until the next valid.
- busy = (state != IDLE).

Decomposition:
- ps2_pkg (src/utils): rx_state_t enum {IDLE, DATA, PARITY, STOP}; constants PS2_PREFIX_EXT=8'hE0 and PS2_PREFIX_BRK=8'hF0.
- Sub-module ps2_input_filter: 2-FF synchronizer plus FILTER_LEN debounce with reset value 1. Instantiated twice, once for clock and once for data.
- Bench uses a PS/2 device model task: 40 µs clock period, data changes mid-high.

Test Plan:
- Send frame 0x1C (bits 0,0,1,1,1,0,0,0; parity 0; stop 1) -> exactly one scancode_valid with scancode=0x1C, is_break=0, is_extended=0.
- Send F0 then 1C -> no pulse after F0; one pulse after 1C with scancode=0x1C, is_break=1. A following 0x1C frame gives is_break=0.
- Send E0, F0, 75 -> single pulse with scancode=0x75, is_extended=1, is_break=1.
- Send 0x1C with parity bit 1 -> frame_error pulse, no valid pulse. Then send clean 0x32 -> valid with 0x32 and both flags 0.
- Stop PS/2 clock after 4 data bits -> frame_error exactly TIMEOUT_CYCLES cycles after the last filtered edge, busy drops. Then send clean 0x1C -> received correctly.
- Inject 3-cycle low glitches on ps2_clk_in in IDLE and mid-frame -> no state change, correct byte received. Assert reset mid-frame -> outputs 0, busy=0, no error pulse; next frame decodes normally.

Source files
------------

// File: rtl/ps2_pkg.sv
// Shared types and constants for the PS/2 scancode receiver.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package ps2_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        DATA   = 2'd1,
        PARITY = 2'd2,
        STOP   = 2'd3
    } rx_state_t;

    localparam logic [7:0] PS2_PREFIX_EXT = 8'hE0;
    localparam logic [7:0] PS2_PREFIX_BRK = 8'hF0;

    // PS/2 uses odd parity: data bits plus parity bit must XOR to 1.
    function automatic logic ps2_parity_ok(input logic [7:0] data, input logic par);
        return ^{data, par};
    endfunction

endpackage

// File: rtl/ps2_input_filter.sv
// Synchronizes one raw PS/2 pin and suppresses pulses shorter than FILTER_LEN cycles.
// Latency: 2 + FILTER_LEN cycles from pin change to filtered change.
// Backpressure: none; continuous sampling path.
module ps2_input_filter #(
    parameter int FILTER_LEN = 8
) (
    input  logic clk,
    input  logic rst,
    input  logic pin,
    output logic filtered
);

    localparam int CW = (FILTER_LEN > 1) ? $clog2(FILTER_LEN) : 1;

    logic          sync_a;
    logic          sync_b;
    logic [CW-1:0] cnt;

    // Two-flop synchronizer; resets to 1 so an idle bus looks idle immediately.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync_a <= 1'b1;
            sync_b <= 1'b1;
        end else begin
            sync_a <= pin;
            sync_b <= sync_a;
        end
    end

    // Output follows the synchronized pin only after FILTER_LEN consecutive differing samples.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt      <= '0;
            filtered <= 1'b1;
        end else if (sync_b == filtered) begin
            cnt <= '0;
        end else if (cnt == CW'(FILTER_LEN - 1)) begin
            cnt      <= '0;
            filtered <= sync_b;
        end else begin
            cnt <= cnt + 1'b1;
        end
    end

endmodule

// File: rtl/ps2_scancode_rx.sv
// Decodes PS/2 keyboard frames into one scancode event per press/release (E0/F0 prefixes folded into flags).
// Latency: event pulses one cycle after the filtered falling edge of the stop bit (pin + 3 + FILTER_LEN).
// Backpressure: none; scancode_valid and frame_error are one-cycle pulses the consumer must take.
module ps2_scancode_rx
    import ps2_pkg::*;
#(
    parameter int FILTER_LEN     = 8,
    parameter int TIMEOUT_CYCLES = 100000
) (
    input  logic       CLOCK_50,
    input  logic       reset,
    input  logic       ps2_clk_in,
    input  logic       ps2_dat_in,
    output logic [7:0] scancode,
    output logic       scancode_valid,
    output logic       is_break,
    output logic       is_extended,
    output logic       frame_error,
    output logic       busy
);

    localparam int TW = $clog2(TIMEOUT_CYCLES + 1);

    logic          clk_f;
    logic          dat_f;
    logic          clk_f_q;
    logic          fall_edge;
    rx_state_t     state;
    logic [2:0]    bit_cnt;
    logic [7:0]    shift;
    logic          par_bit;
    logic [TW-1:0] tmo_cnt;
    logic          brk_flag;
    logic          ext_flag;

    ps2_input_filter #(.FILTER_LEN(FILTER_LEN)) u_clk_filter (
        .clk      (CLOCK_50),
        .rst      (reset),
        .pin      (ps2_clk_in),
        .filtered (clk_f)
    );

    ps2_input_filter #(.FILTER_LEN(FILTER_LEN)) u_dat_filter (
        .clk      (CLOCK_50),
        .rst      (reset),
        .pin      (ps2_dat_in),
        .filtered (dat_f)
    );

    // Previous filtered clock, for falling-edge detection.
    always_ff @(posedge CLOCK_50 or posedge reset) begin
        if (reset) clk_f_q <= 1'b1;
        else       clk_f_q <= clk_f;
    end

    assign fall_edge = clk_f_q & ~clk_f;
    assign busy      = (state != IDLE);

    // Frame FSM, inter-edge timeout, prefix tracking and registered event outputs.
    always_ff @(posedge CLOCK_50 or posedge reset) begin
        if (reset) begin
            state          <= IDLE;
            bit_cnt        <= '0;
            shift          <= '0;
            par_bit        <= 1'b0;
            tmo_cnt        <= '0;
            brk_flag       <= 1'b0;
            ext_flag       <= 1'b0;
            scancode       <= '0;
            scancode_valid <= 1'b0;
            is_break       <= 1'b0;
            is_extended    <= 1'b0;
            frame_error    <= 1'b0;
        end else begin
            scancode_valid <= 1'b0;
            frame_error    <= 1'b0;
            if (state == IDLE) begin
                // Counter parked in IDLE so prefix flags survive any gap between frames.
                tmo_cnt <= '0;
                if (fall_edge && !dat_f) begin
                    state   <= DATA;
                    bit_cnt <= '0;
                    tmo_cnt <= TW'(1);
                end
            end else if (fall_edge) begin
                // The edge cycle itself counts as the first cycle of the new interval.
                tmo_cnt <= TW'(1);
                case (state)
                    DATA: begin
                        shift <= {dat_f, shift[7:1]};
                        if (bit_cnt == 3'd7) state <= PARITY;
                        else                 bit_cnt <= bit_cnt + 3'd1;
                    end
                    PARITY: begin
                        par_bit <= dat_f;
                        state   <= STOP;
                    end
                    STOP: begin
                        state <= IDLE;
                        if (!ps2_parity_ok(shift, par_bit) || !dat_f) begin
                            frame_error <= 1'b1;
                            brk_flag    <= 1'b0;
                            ext_flag    <= 1'b0;
                        end else if (shift == PS2_PREFIX_EXT) begin
                            ext_flag <= 1'b1;
                        end else if (shift == PS2_PREFIX_BRK) begin
                            brk_flag <= 1'b1;
                        end else begin
                            scancode_valid <= 1'b1;
                            scancode       <= shift;
                            is_break       <= brk_flag;
                            is_extended    <= ext_flag;
                            brk_flag       <= 1'b0;
                            ext_flag       <= 1'b0;
                        end
                    end
                    default: ;
                endcase
            end else if (tmo_cnt == TW'(TIMEOUT_CYCLES - 1)) begin
                // Keyboard stalled mid-frame: abandon the frame and any pending prefix.
                state       <= IDLE;
                tmo_cnt     <= '0;
                frame_error <= 1'b1;
                brk_flag    <= 1'b0;
                ext_flag    <= 1'b0;
            end else begin
                tmo_cnt <= tmo_cnt + 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_ps2_scancode_rx.sv
// Bench for ps2_scancode_rx: PS/2 device model driving directed and random frames.
// Latency: n/a.
// Backpressure: n/a.
`timescale 1ns/1ps
module tb_ps2_scancode_rx;

    localparam int FILTER_LEN     = 8;
    localparam int TIMEOUT_CYCLES = 300;
    localparam int HALF           = 20;   // PS/2 half period in system clocks (scaled-down 40 us period)
    localparam logic [31:0] EV_VAL = 32'h0001_0000;
    localparam logic [31:0] EV_ERR = 32'h0002_0000;
    localparam logic [31:0] EV_BAD = 32'h0004_0000;

    logic       CLOCK_50   = 1'b0;
    logic       reset      = 1'b1;
    logic       ps2_clk_in = 1'b1;
    logic       ps2_dat_in = 1'b1;
    logic [7:0] scancode;
    logic       scancode_valid;
    logic       is_break;
    logic       is_extended;
    logic       frame_error;
    logic       busy;

    int n_tests = 0;
    int n_fail  = 0;
    int cyc     = 0;
    int err_cyc = -1;
    int last_fall_cyc = 0;

    logic [31:0] obs_q[$];
    logic [31:0] exp_q[$];

    // Reference state: pending prefixes and last reported event
    logic       m_brk = 1'b0, m_ext = 1'b0;
    logic [7:0] m_code = 8'h00;
    logic       m_cbrk = 1'b0, m_cext = 1'b0;

    ps2_scancode_rx #(.FILTER_LEN(FILTER_LEN), .TIMEOUT_CYCLES(TIMEOUT_CYCLES)) dut (
        .CLOCK_50       (CLOCK_50),
        .reset          (reset),
        .ps2_clk_in     (ps2_clk_in),
        .ps2_dat_in     (ps2_dat_in),
        .scancode       (scancode),
        .scancode_valid (scancode_valid),
        .is_break       (is_break),
        .is_extended    (is_extended),
        .frame_error    (frame_error),
        .busy           (busy)
    );

    always #10 CLOCK_50 = ~CLOCK_50;

    always @(posedge CLOCK_50) cyc <= cyc + 1;

    // Event monitor, sampled mid-cycle
    always @(negedge CLOCK_50) begin
        if (!reset) begin
            if (scancode_valid && frame_error) begin
                obs_q.push_back(EV_BAD);
            end else if (scancode_valid) begin
                obs_q.push_back(EV_VAL | ({24'h0, scancode} << 2) | {30'h0, is_break, is_extended});
            end else if (frame_error) begin
                obs_q.push_back(EV_ERR);
                err_cyc = cyc;
            end
        end
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(posedge CLOCK_50);
        #1;
    endtask

    // Device model: data changes mid-high, clock low for HALF cycles per bit.
    task automatic ps2_bits(input logic [10:0] bits, input int nbits, input int glitch_at);
        for (int i = 0; i < nbits; i++) begin
            if (i == glitch_at) begin
                tick(2);
                ps2_clk_in = 1'b0;
                tick(3);
                ps2_clk_in = 1'b1;
                tick(HALF/2 - 5);
            end else begin
                tick(HALF/2);
            end
            ps2_dat_in = bits[i];
            tick(HALF/2);
            ps2_clk_in    = 1'b0;
            last_fall_cyc = cyc;
            tick(HALF);
            ps2_clk_in = 1'b1;
        end
        tick(HALF/2);
        ps2_dat_in = 1'b1;
    endtask

    function automatic logic [10:0] frame_bits(input logic [7:0] b, input bit bad_par, input bit bad_stop);
        logic par;
        par = ~(^b) ^ bad_par;
        return {~bad_stop, par, b, 1'b0};
    endfunction

    // Reference decoding of one complete frame.
    task automatic model_frame(input logic [7:0] b, input bit bad);
        if (bad) begin
            exp_q.push_back(EV_ERR);
            m_brk = 1'b0;
            m_ext = 1'b0;
        end else if (b == 8'hE0) begin
            m_ext = 1'b1;
        end else if (b == 8'hF0) begin
            m_brk = 1'b1;
        end else begin
            exp_q.push_back(EV_VAL | ({24'h0, b} << 2) | {30'h0, m_brk, m_ext});
            m_code = b;
            m_cbrk = m_brk;
            m_cext = m_ext;
            m_brk  = 1'b0;
            m_ext  = 1'b0;
        end
    endtask

    task automatic send(input logic [7:0] b, input bit bad_par, input bit bad_stop, input int glitch_at);
        ps2_bits(frame_bits(b, bad_par, bad_stop), 11, glitch_at);
        model_frame(b, bad_par | bad_stop);
        tick($urandom_range(1, 30));
    endtask

    task automatic compare_events(input string tag);
        tick(FILTER_LEN + 6);
        chk({tag, "/count"}, obs_q.size(), exp_q.size());
        while (obs_q.size() > 0 && exp_q.size() > 0)
            chk({tag, "/event"}, obs_q.pop_front(), exp_q.pop_front());
        obs_q.delete();
        exp_q.delete();
        chk({tag, "/held"}, {21'h0, is_extended, is_break, scancode}, {21'h0, m_cext, m_cbrk, m_code});
        chk({tag, "/idle"}, {31'h0, busy}, 32'h0);
    endtask

    task automatic model_reset();
        m_brk = 1'b0; m_ext = 1'b0; m_code = 8'h00; m_cbrk = 1'b0; m_cext = 1'b0;
    endtask

    initial begin
        int pre, gl;
        logic [7:0] b;
        bit err, coin;

        tick(5);
        chk("reset_outs", {18'h0, scancode, scancode_valid, is_break, is_extended, frame_error, busy}, 32'h0);
        reset = 1'b0;
        tick(20);

        send(8'h1C, 0, 0, -1);
        compare_events("plain_1c");

        send(8'hF0, 0, 0, -1);
        compare_events("brk_prefix_only");
        send(8'h1C, 0, 0, -1);
        compare_events("break_1c");
        send(8'h1C, 0, 0, -1);
        compare_events("after_break");

        send(8'hE0, 0, 0, -1);
        send(8'hF0, 0, 0, -1);
        send(8'h75, 0, 0, -1);
        compare_events("ext_break_75");

        send(8'hF0, 0, 0, -1);
        send(8'h1C, 1, 0, -1);
        compare_events("bad_parity");
        send(8'h32, 0, 0, -1);
        compare_events("clean_32");

        send(8'h5A, 0, 1, -1);
        compare_events("bad_stop");

        // Timeout: F0 prefix, then a frame that stalls after 4 data bits
        send(8'hF0, 0, 0, -1);
        err_cyc = -1;
        ps2_bits(frame_bits(8'h1C, 0, 0), 5, -1);
        chk("busy_midframe", {31'h0, busy}, 32'h1);
        for (int i = 0; i < 4 * TIMEOUT_CYCLES && obs_q.size() == 0; i++) tick(1);
        chk("timeout_delay", err_cyc - last_fall_cyc, FILTER_LEN + 2 + TIMEOUT_CYCLES);
        exp_q.push_back(EV_ERR);
        m_brk = 1'b0;
        m_ext = 1'b0;
        compare_events("timeout");
        send(8'h1C, 0, 0, -1);
        compare_events("after_timeout");

        // Short clock glitches, idle and mid-frame
        ps2_clk_in = 1'b0;
        tick(3);
        ps2_clk_in = 1'b1;
        compare_events("glitch_idle");
        send(8'h2B, 0, 0, 4);
        compare_events("glitch_mid");

        // Reset in the middle of a frame, with a prefix pending
        send(8'hE0, 0, 0, -1);
        ps2_bits(frame_bits(8'h44, 0, 0), 4, -1);
        chk("busy_before_rst", {31'h0, busy}, 32'h1);
        reset = 1'b1;
        tick(2);
        chk("midframe_rst", {18'h0, scancode, scancode_valid, is_break, is_extended, frame_error, busy}, 32'h0);
        reset = 1'b0;
        model_reset();
        exp_q.delete();
        obs_q.delete();
        compare_events("post_reset");
        send(8'h44, 0, 0, -1);
        compare_events("rst_then_44");

        // Random prefixes, bytes, errors and glitches
        for (int r = 0; r < 10; r++) begin
            pre = $urandom_range(0, 3);
            if (pre[0]) send(8'hE0, 0, 0, -1);
            if (pre[1]) send(8'hF0, 0, 0, -1);
            b    = 8'($urandom_range(0, 255));
            err  = ($urandom_range(0, 4) == 0);
            coin = ($urandom_range(0, 1) == 1);
            gl   = ($urandom_range(0, 2) == 0) ? int'($urandom_range(0, 10)) : -1;
            send(b, err & coin, err & ~coin, gl);
            compare_events("random");
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
